// File: rtl/pipe_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_t : controller state encoding (RUN, LDSTALL, FLUSH, MEMWAIT)
//   fwd_sel_t  : EX operand source select (FWD_RF, FWD_WB, FWD_MEM)
//   REG_ZERO   : hard-wired zero register; never a hazard or forward source
// -----------------------------------------------------------------------------
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_fwd_unit.sv
// -----------------------------------------------------------------------------
// pipe_fwd_unit
// Purely combinational EX-stage forwarding compare. For each EX source operand
// the youngest in-flight writer wins: EX/MEM result first, then MEM/WB, else
// the register-file value. Register zero is never forwarded.
// Ports:
//   i_en                      : 0 forces both selects to FWD_RF
//   i_ex_rs, i_ex_rt          : source specifiers held in ID/EX
//   i_mem_reg_write, i_mem_dst: EX/MEM writeback info
//   i_wb_reg_write,  i_wb_dst : MEM/WB writeback info
//   o_fwd_a, o_fwd_b          : operand selects for rs / rt
// -----------------------------------------------------------------------------
module pipe_fwd_unit
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_en,
    input  logic [REG_W-1:0] i_ex_rs,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_mem_reg_write,
    input  logic [REG_W-1:0] i_mem_dst,
    input  logic             i_wb_reg_write,
    input  logic [REG_W-1:0] i_wb_dst,
    output fwd_sel_t         o_fwd_a,
    output fwd_sel_t         o_fwd_b
);

    logic w_mem_ok;
    logic w_wb_ok;

    // MEM is checked first so it beats WB when both hold the same register.
    function automatic fwd_sel_t pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_RF;
    endfunction

    assign w_mem_ok = i_mem_reg_write && (i_mem_dst != REG_W'(REG_ZERO));
    assign w_wb_ok  = i_wb_reg_write  && (i_wb_dst  != REG_W'(REG_ZERO));

    assign o_fwd_a = i_en ? pick(w_mem_ok && (i_mem_dst == i_ex_rs),
                                 w_wb_ok  && (i_wb_dst  == i_ex_rs)) : FWD_RF;
    assign o_fwd_b = i_en ? pick(w_mem_ok && (i_mem_dst == i_ex_rt),
                                 w_wb_ok  && (i_wb_dst  == i_ex_rt)) : FWD_RF;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Control side of the five-stage pipeline: stage enables, stage flushes, EX
// forwarding selects, the stall/flush state machine and the data-memory wait
// watchdog.
// Optional build macro: HAZ_PERF_CNT_EN enables the stall_cycles/flush_count
// performance counters; without it both ports read constant zero.
// Ports:
//   clk, rst (async, active-low)
//   id_rs, id_rt, id_uses_rt          : ID instruction sources
//   ex_rs, ex_rt, ex_mem_read, ex_dst : ID/EX contents
//   ex_branch_taken                   : branch/jump resolved taken in EX
//   mem_access, dmem_ready            : data-memory handshake
//   mem_reg_write, mem_dst            : EX/MEM writeback info
//   wb_reg_write, wb_dst              : MEM/WB writeback info
//   pc_en..memwb_en                   : stage load enables
//   ifid_flush, idex_flush            : stage clears on the next edge
//   fwd_a, fwd_b                      : EX operand selects
//   state_o                           : current controller state
//   mem_timeout                       : sticky watchdog error
//   stall_cycles, flush_count         : performance counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int TIMEOUT  = 64,
    parameter int TO_CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_dst,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_dst,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state_o,
    output logic             mem_timeout,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_count
);

    hz_state_t           r_state;
    hz_state_t           w_state_nxt;
    logic [TO_CNT_W-1:0] r_wdog;
    logic                r_timeout;
    logic                w_mem_wait;
    logic                w_ld_use;
    logic                w_branch_flush;
    fwd_sel_t            w_fwd_a;
    fwd_sel_t            w_fwd_b;

    assign w_mem_wait = mem_access && !dmem_ready;

    assign w_ld_use = ex_mem_read && (ex_dst != REG_W'(REG_ZERO)) &&
                      ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

    // A branch held in EX during a memory freeze is only acted on once the
    // freeze releases, because the wait check has priority.
    assign w_branch_flush = rst && !w_mem_wait && ex_branch_taken;

    // LDSTALL and FLUSH are one-cycle markers: every state runs the same
    // fresh detection, so the outputs depend only on the current inputs.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        w_state_nxt = RUN;
        if (!rst) begin
            w_state_nxt = RUN;
        end else if (w_mem_wait) begin
            w_state_nxt = MEMWAIT;
        end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            w_state_nxt = FLUSH;
        end else if (w_ld_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX, drain the rest.
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            idex_flush  = 1'b1;
            w_state_nxt = LDSTALL;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= RUN;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mem_wait) begin
                // Saturate so a very long wait cannot wrap the counter.
                if (r_wdog != TO_CNT_W'(TIMEOUT))
                    r_wdog <= r_wdog + 1'b1;
                // This wait cycle brings the count to TIMEOUT.
                if (r_wdog >= TO_CNT_W'(TIMEOUT - 1))
                    r_timeout <= 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign state_o     = r_state;
    assign mem_timeout = r_timeout;

    pipe_fwd_unit #(
        .REG_W (REG_W)
    ) u_fwd (
        .i_en            (rst),
        .i_ex_rs         (ex_rs),
        .i_ex_rt         (ex_rt),
        .i_mem_reg_write (mem_reg_write),
        .i_mem_dst       (mem_dst),
        .i_wb_reg_write  (wb_reg_write),
        .i_wb_dst        (wb_dst),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    assign fwd_a = w_fwd_a;
    assign fwd_b = w_fwd_b;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // pc_en is already forced low during reset, but reset also clears here,
    // so only held-PC cycles in normal operation are counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_en)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_branch_flush)
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (TIMEOUT=4). Each step pushes the
// expected enables/flushes/forward selects/state to a queue when the inputs
// are driven; the entry is popped and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;

    typedef struct {
        string      tag;
        logic [4:0] en;
        logic [1:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] st;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic             id_uses_rt, ex_mem_read, ex_branch_taken;
    logic             mem_access, dmem_ready, mem_reg_write, wb_reg_write;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, mem_timeout;
    logic [1:0]       fwd_a, fwd_b, state_o;
    logic [31:0]      stall_cycles, flush_count;

    exp_t  sb_q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    exp_stall = 0;
    int    exp_flush = 0;

    pipe_hazard_ctrl #(
        .REG_W    (REG_W),
        .TIMEOUT  (4),
        .TO_CNT_W (7)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_dst          (ex_dst),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .mem_reg_write   (mem_reg_write),
        .mem_dst         (mem_dst),
        .wb_reg_write    (wb_reg_write),
        .wb_dst          (wb_dst),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .state_o         (state_o),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_mem_read = 1'b0; ex_dst = '0;
        ex_branch_taken = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b0;
        mem_reg_write = 1'b0; mem_dst = '0;
        wb_reg_write = 1'b0; wb_dst = '0;
    endtask

    // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid_flush, idex_flush}.
    task automatic step(input string tag, input logic [4:0] en, input logic [1:0] fl,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st);
        exp_t e;
        exp_t g;
        e.tag = tag; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.st = st;
        sb_q.push_back(e);
        if (rst && !en[4]) exp_stall++;
        if (fl == 2'b11)   exp_flush++;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            g = sb_q.pop_front();
            chk({g.tag, ".en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(g.en));
            chk({g.tag, ".fl"}, 32'({ifid_flush, idex_flush}), 32'(g.fl));
            chk({g.tag, ".fa"}, 32'(fwd_a), 32'(g.fa));
            chk({g.tag, ".fb"}, 32'(fwd_b), 32'(g.fb));
            chk({g.tag, ".st"}, 32'(state_o), 32'(g.st));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
`ifdef HAZ_PERF_CNT_EN
        chk({tag, ".stall"}, stall_cycles, 32'(exp_stall));
        chk({tag, ".flush"}, flush_count, 32'(exp_flush));
`else
        chk({tag, ".stall"}, stall_cycles, 32'd0);
        chk({tag, ".flush"}, flush_count, 32'd0);
`endif
    endtask

    initial begin
        // Reset state: forwarding match and a branch present, all must be masked.
        rst = 1'b0;
        clr();
        ex_rs = 5'd7; ex_rt = 5'd7; mem_reg_write = 1'b1; mem_dst = 5'd7;
        ex_branch_taken = 1'b1;
        #1;
        step("rst", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd0);
        chk("rst.timeout", 32'(mem_timeout), 32'd0);
        chk_cnt("rst");
        rst = 1'b1;
        clr();
        step("idle", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);

        // Load-use on rs: one bubble, LDSTALL for one cycle.
        ex_mem_read = 1'b1; ex_dst = 5'd5; id_rs = 5'd5;
        step("lu", 5'b00111, 2'b01, 2'b00, 2'b00, 2'd0);
        clr();
        step("lu_st", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd1);
        step("lu_run", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);
        chk_cnt("lu");

        // rt match ignored unless the ID instruction reads rt.
        ex_mem_read = 1'b1; ex_dst = 5'd6; id_rt = 5'd6; id_rs = 5'd5;
        step("lu_rt_unused", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);
        id_uses_rt = 1'b1;
        step("lu_rt", 5'b00111, 2'b01, 2'b00, 2'b00, 2'd0);
        // Back-to-back load-use on a new pair stalls again.
        ex_dst = 5'd9; id_rs = 5'd9; id_uses_rt = 1'b0;
        step("lu_b2b", 5'b00111, 2'b01, 2'b00, 2'b00, 2'd1);
        // Load into r0 never stalls.
        ex_dst = 5'd0; id_rs = 5'd0;
        step("lu_r0", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd1);
        clr();
        step("lu_end", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);

        // Forwarding priority and register-zero exclusion.
        ex_rs = 5'd7; ex_rt = 5'd7; mem_dst = 5'd7; wb_dst = 5'd7;
        mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        step("fwd_mem", 5'b11111, 2'b00, 2'b10, 2'b10, 2'd0);
        mem_reg_write = 1'b0;
        step("fwd_wb", 5'b11111, 2'b00, 2'b01, 2'b01, 2'd0);
        ex_rs = 5'd0;
        step("fwd_rf", 5'b11111, 2'b00, 2'b00, 2'b01, 2'd0);
        mem_reg_write = 1'b1; mem_dst = 5'd0;
        step("fwd_r0", 5'b11111, 2'b00, 2'b00, 2'b01, 2'd0);
        clr();

        // Branch and load-use together: branch wins, no stall.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd5; id_rs = 5'd5;
        step("br_lu", 5'b11111, 2'b11, 2'b00, 2'b00, 2'd0);
        clr();
        step("br_st", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd2);
        step("br_run", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);
        chk_cnt("br");

        // Memory wait with a taken branch held: frozen, then flush on release.
        mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
        step("mw1", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd0);
        step("mw2", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd3);
        step("mw3", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd3);
        dmem_ready = 1'b1;
        step("mw_rel", 5'b11111, 2'b11, 2'b00, 2'b00, 2'd3);
        clr();
        step("mw_st", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd2);
        step("mw_run", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);
        chk("mw.timeout", 32'(mem_timeout), 32'd0);
        chk_cnt("mw");

        // Watchdog: sticky error after the 4th consecutive wait cycle.
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step($sformatf("to_w%0d", k), 5'b00000, 2'b00, 2'b00, 2'b00,
                 (k == 1) ? 2'd0 : 2'd3);
            chk($sformatf("to_flag%0d", k), 32'(mem_timeout), (k >= 4) ? 32'd1 : 32'd0);
        end
        dmem_ready = 1'b1;
        step("to_rel", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd3);
        clr();
        step("to_run", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk_cnt("to");

        // Asynchronous reset in the middle of a memory wait.
        mem_access = 1'b1; dmem_ready = 1'b0;
        step("r6_w1", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd0);
        step("r6_w2", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("r6.st", 32'(state_o), 32'd0);
        chk("r6.en", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
        chk("r6.fl", 32'({ifid_flush, idex_flush}), 32'd0);
        chk("r6.timeout", 32'(mem_timeout), 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        chk_cnt("r6");
        @(posedge clk);
        #2;
        rst = 1'b1;
        clr();
        step("r6_run", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);
        // Watchdog restarted from zero: three waits stay below TIMEOUT.
        mem_access = 1'b1; dmem_ready = 1'b0;
        step("r6_w3", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd0);
        step("r6_w4", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd3);
        step("r6_w5", 5'b00000, 2'b00, 2'b00, 2'b00, 2'd3);
        chk("r6.wdog", 32'(mem_timeout), 32'd0);
        dmem_ready = 1'b1;
        step("r6_rel", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd3);
        clr();
        step("r6_end", 5'b11111, 2'b00, 2'b00, 2'b00, 2'd0);
        chk_cnt("r6_end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
